// File: rtl/osd_dii_pkg.sv
// Shared types for the DII packet buffer: flit layout and input framing states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package osd_dii_pkg;

  localparam int DII_DATA_W = 16;

  typedef struct packed {
    logic [DII_DATA_W-1:0] data;
    logic                  first;
    logic                  last;
  } dii_flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } dii_frame_state_e;

endpackage

// File: rtl/osd_dii_buf_mem.sv
// Flit storage for the packet buffer: DEPTH x dii_flit_t simple dual-port RAM, no reset.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; the owner guarantees it never writes a slot that is still unread.
module osd_dii_buf_mem
  import osd_dii_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  dii_flit_t         wr_flit,
  input  logic [ADDR_W-1:0] rd_addr,
  output dii_flit_t         rd_flit
);

  dii_flit_t mem_q [DEPTH];

  // Store the accepted flit in its slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_flit;
    end
  end

  assign rd_flit = mem_q[rd_addr];

endmodule

// File: rtl/osd_dii_packet_buffer.sv
// Store-and-forward DII flit buffer; drops flits outside a first..last frame. Status ports: OSD_DII_BUF_STATUS_EN.
// Latency: last flit accepted in cycle N -> out_valid in cycle N+1; then 1 flit/cycle.
// Backpressure: in_ready = !full (no same-cycle bypass); out_valid holds with stable data until out_ready.
module osd_dii_packet_buffer
  import osd_dii_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DII_DATA_W-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DII_DATA_W-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef OSD_DII_BUF_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic [ADDR_W:0]  wr_ptr, wr_ptr_nxt;
  logic [ADDR_W:0]  rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] pkt_cnt, pkt_cnt_nxt;
  logic             flush, flush_nxt;
  dii_frame_state_e state, state_nxt;

  logic      empty, full;
  logic      in_fire, wr_en, rd_en;
  logic      cnt_inc, cnt_dec;
  dii_flit_t wr_flit, rd_flit;

  // Wrap bit (MSB) distinguishes full from empty when the slot addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign in_ready = !full;
  assign in_fire  = in_valid && in_ready;
  // Flits arriving outside a frame are accepted but never stored.
  assign wr_en    = in_fire && ((state == PKT) || in_first);

  // Output is released only for complete packets, or when an oversize packet forces a flush.
  assign out_valid = !empty && ((pkt_cnt != '0) || flush);
  assign rd_en     = out_valid && out_ready;

  assign wr_flit   = '{data: in_data, first: in_first, last: in_last};
  assign out_data  = rd_flit.data;
  assign out_first = rd_flit.first;
  assign out_last  = rd_flit.last;

  assign cnt_inc = wr_en && in_last;
  assign cnt_dec = rd_en && rd_flit.last;

  // Next-state for pointers, framing FSM, packet count and flush flag.
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    pkt_cnt_nxt = pkt_cnt;
    state_nxt   = state;

    if (wr_en) wr_ptr_nxt = wr_ptr + (ADDR_W+1)'(1);
    if (rd_en) rd_ptr_nxt = rd_ptr + (ADDR_W+1)'(1);

    case ({cnt_inc, cnt_dec})
      2'b10:   pkt_cnt_nxt = pkt_cnt + CNT_W'(1);
      2'b01:   pkt_cnt_nxt = pkt_cnt - CNT_W'(1);
      default: pkt_cnt_nxt = pkt_cnt;
    endcase

    if (in_fire) begin
      if (state == IDLE) begin
        if (in_first && !in_last) state_nxt = PKT;
      end else if (in_last) begin
        state_nxt = IDLE;
      end
    end

    // A packet that fills the whole buffer can never complete; stream it out until its last flit.
    flush_nxt = (flush && !cnt_dec) || (full && (pkt_cnt == '0));
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      flush   <= 1'b0;
      state   <= IDLE;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      pkt_cnt <= pkt_cnt_nxt;
      flush   <= flush_nxt;
      state   <= state_nxt;
    end
  end

`ifdef OSD_DII_BUF_STATUS_EN
  // Status mirrors the state the buffer holds after this cycle's transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      pkt_count <= '0;
    end else begin
      occupancy <= wr_ptr_nxt - rd_ptr_nxt;
      pkt_count <= pkt_cnt_nxt;
    end
  end
`endif

  osd_dii_buf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_flit (wr_flit),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_flit (rd_flit)
  );

endmodule
